iot_filter_param: RTL and testbench

IOT_FILTER_PARAM -- requirements
Module: iot_filter_param

---
 rtl/iot_filter_param_if.sv | 25 ++
 rtl/iot_filter_param.sv | 171 +++++++++++++++++
 tb/tb_iot_filter_param.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iot_filter_param_if.sv
// Bus bundle for iot_filter_param: beat input, function/bound controls,
// and the busy/valid/result outputs.
interface iot_filter_param_if #(
  parameter int DATA_W = 128,
  parameter int IN_W   = 8
);
  logic              in_en;
  logic [IN_W-1:0]   iot_in;
  logic [2:0]        fn_sel;
  logic [DATA_W-1:0] low_bound;
  logic [DATA_W-1:0] high_bound;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] iot_out;

  modport master (
    output in_en, iot_in, fn_sel, low_bound, high_bound,
    input  busy, valid, iot_out
  );

  modport slave (
    input  in_en, iot_in, fn_sel, low_bound, high_bound,
    output busy, valid, iot_out
  );
endinterface

// File: rtl/iot_filter_param.sv
// Batch filter for a beat-serial data stream. Beats are assembled MSB-first
// into words; each completed word gets one PROC cycle in which it feeds the
// per-batch statistic selected by fn_sel (max, min, average, in-range,
// out-of-range, running peak max/min). Results are strobed on valid.
module iot_filter_param #(
  parameter int DATA_W = 128,
  parameter int IN_W   = 8,
  parameter int GROUP  = 8
) (
  input logic               clk,
  input logic               rst,
  iot_filter_param_if.slave bus
);

  localparam int BEATS = DATA_W / IN_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = $clog2(GROUP);
  localparam int SUM_W = DATA_W + GW;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [GW-1:0]  LAST_WORD = GW'(GROUP - 1);

  localparam logic [2:0] FN_MAX     = 3'd1;
  localparam logic [2:0] FN_MIN     = 3'd2;
  localparam logic [2:0] FN_AVG     = 3'd3;
  localparam logic [2:0] FN_EXTRACT = 3'd4;
  localparam logic [2:0] FN_EXCLUDE = 3'd5;
  localparam logic [2:0] FN_PMAX    = 3'd6;
  localparam logic [2:0] FN_PMIN    = 3'd7;

  typedef enum logic {COLLECT = 1'b0, PROC = 1'b1} state_t;

  state_t              r_state;
  logic [BCW-1:0]      r_beat_cnt;
  logic [GW-1:0]       r_word_cnt;
  logic [2:0]          r_fn;
  logic [DATA_W-1:0]   r_word_p0;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   r_min;
  logic [SUM_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_peak;
  logic [DATA_W-1:0]   r_out_p1;
  logic                r_vld_p1;
  logic                r_busy;

  logic [DATA_W-1:0]   w_word_shift;
  logic                w_first;
  logic                w_last;
  logic [DATA_W-1:0]   w_bmax;
  logic [DATA_W-1:0]   w_bmin;
  logic [SUM_W-1:0]    w_sum;
  logic                w_hit;
  logic                w_peak_upd;
  logic [DATA_W-1:0]   w_res;

  // Division by GROUP is a right shift; dropping the low bits is the floor.
  function automatic logic [DATA_W-1:0] f_avg(input logic [SUM_W-1:0] sum);
    return sum[SUM_W-1:GW];
  endfunction

  // New beat enters at the bottom, so the first beat ends up most significant.
  assign w_word_shift = (r_word_p0 << IN_W) | DATA_W'(bus.iot_in);

  // Running batch statistics including the word currently in PROC; the
  // first word of a batch restarts them instead of merging with stale state.
  assign w_first = (r_word_cnt == '0);
  assign w_last  = (r_word_cnt == LAST_WORD);
  assign w_bmax  = (w_first || (r_word_p0 > r_max)) ? r_word_p0 : r_max;
  assign w_bmin  = (w_first || (r_word_p0 < r_min)) ? r_word_p0 : r_min;
  assign w_sum   = (w_first ? '0 : r_sum) + SUM_W'(r_word_p0);

  // Decide whether this PROC cycle strobes, and with what value.
  always_comb begin
    w_hit      = 1'b0;
    w_peak_upd = 1'b0;
    w_res      = r_out_p1;
    case (r_fn)
      FN_MAX: if (w_last) begin
        w_hit = 1'b1;
        w_res = w_bmax;
      end
      FN_MIN: if (w_last) begin
        w_hit = 1'b1;
        w_res = w_bmin;
      end
      FN_AVG: if (w_last) begin
        w_hit = 1'b1;
        w_res = f_avg(w_sum);
      end
      // An empty or inverted window can never satisfy both strict compares.
      FN_EXTRACT: if ((r_word_p0 > bus.low_bound) && (r_word_p0 < bus.high_bound)) begin
        w_hit = 1'b1;
        w_res = r_word_p0;
      end
      FN_EXCLUDE: if ((r_word_p0 < bus.low_bound) || (r_word_p0 > bus.high_bound)) begin
        w_hit = 1'b1;
        w_res = r_word_p0;
      end
      FN_PMAX: if (w_last && (w_bmax > r_peak)) begin
        w_hit      = 1'b1;
        w_peak_upd = 1'b1;
        w_res      = w_bmax;
      end
      FN_PMIN: if (w_last && (w_bmin < r_peak)) begin
        w_hit      = 1'b1;
        w_peak_upd = 1'b1;
        w_res      = w_bmin;
      end
      default: ;
    endcase
  end

  // Collect/process FSM with beat assembly, batch state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= COLLECT;
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
      r_fn       <= '0;
      r_word_p0  <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_sum      <= '0;
      r_peak     <= '0;
      r_out_p1   <= '0;
      r_vld_p1   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      case (r_state)
        // ---- stage p0: beat assembly ----
        COLLECT: if (bus.in_en) begin
          r_word_p0 <= w_word_shift;
          if ((r_beat_cnt == '0) && (r_word_cnt == '0)) begin
            r_fn <= bus.fn_sel;
            // A function change restarts the peak from the neutral value.
            if (bus.fn_sel != r_fn)
              r_peak <= (bus.fn_sel == FN_PMIN) ? '1 : '0;
          end
          if (r_beat_cnt == LAST_BEAT) begin
            r_beat_cnt <= '0;
            r_state    <= PROC;
            r_busy     <= 1'b1;
          end else begin
            r_beat_cnt <= r_beat_cnt + BCW'(1);
          end
        end
        // ---- stage p1: word evaluation and result register ----
        PROC: begin
          r_state    <= COLLECT;
          r_busy     <= 1'b0;
          r_word_cnt <= r_word_cnt + GW'(1);
          r_max      <= w_bmax;
          r_min      <= w_bmin;
          r_sum      <= w_sum;
          if (w_hit) begin
            r_vld_p1 <= 1'b1;
            r_out_p1 <= w_res;
          end
          if (w_peak_upd)
            r_peak <= w_res;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.valid   = r_vld_p1;
  assign bus.iot_out = r_out_p1;

endmodule

// File: tb/tb_iot_filter_param.sv
// Bench for iot_filter_param (DATA_W=16, IN_W=8, GROUP=4): directed
// scenarios with literal expectations plus randomized batches against a
// batch-level reference model, with outputs compared every cycle.
module tb_iot_filter_param;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int GR = 4;

  logic clk;
  logic rst;

  iot_filter_param_if #(.DATA_W(DW), .IN_W(IW)) bus ();

  iot_filter_param #(.DATA_W(DW), .IN_W(IW), .GROUP(GR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int n_strobe;
  int cyc;

  logic          exp_valid;
  logic          exp_busy;
  logic [DW-1:0] exp_out;

  // reference model state: words of the current batch, sampled function, peak
  logic [DW-1:0] m_bw [GR];
  int            m_widx;
  logic [2:0]    m_fn;
  logic [2:0]    m_prev;
  logic [DW-1:0] m_peak;

  task automatic model_reset();
    m_widx    = 0;
    m_fn      = 3'd0;
    m_prev    = 3'd0;
    m_peak    = '0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_out   = '0;
  endtask

  task automatic model_word(input logic [DW-1:0] w, input logic [2:0] fn);
    logic          hit;
    logic [DW-1:0] r;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    int            sum;
    if (m_widx == 0) begin
      m_fn = fn;
      if (fn != m_prev) m_peak = (fn == 3'd7) ? 16'hFFFF : 16'h0000;
      m_prev = fn;
    end
    m_bw[m_widx] = w;
    hit = 1'b0;
    r   = exp_out;
    mx  = m_bw[0];
    mn  = m_bw[0];
    sum = 0;
    for (int i = 0; i <= m_widx; i++) begin
      if (m_bw[i] > mx) mx = m_bw[i];
      if (m_bw[i] < mn) mn = m_bw[i];
      sum += int'(m_bw[i]);
    end
    if (m_fn == 3'd4) begin
      if (bus.low_bound < w && w < bus.high_bound) begin hit = 1'b1; r = w; end
    end else if (m_fn == 3'd5) begin
      if (w < bus.low_bound || w > bus.high_bound) begin hit = 1'b1; r = w; end
    end else if (m_widx == GR - 1) begin
      case (m_fn)
        3'd1: begin hit = 1'b1; r = mx; end
        3'd2: begin hit = 1'b1; r = mn; end
        3'd3: begin hit = 1'b1; r = DW'(sum / GR); end
        3'd6: if (mx > m_peak) begin hit = 1'b1; r = mx; m_peak = mx; end
        3'd7: if (mn < m_peak) begin hit = 1'b1; r = mn; m_peak = mn; end
        default: ;
      endcase
    end
    exp_valid = hit;
    exp_out   = r;
    m_widx    = (m_widx + 1) % GR;
  endtask

  task automatic compare();
    n_vec++;
    if (bus.valid !== exp_valid || bus.busy !== exp_busy || bus.iot_out !== exp_out) begin
      n_bad++;
      $display("FAIL cycle %0d outputs: valid/busy/out got %b/%b/%h want %b/%b/%h",
               cyc, bus.valid, bus.busy, bus.iot_out, exp_valid, exp_busy, exp_out);
    end
    if (bus.valid === 1'b1) n_strobe++;
  endtask

  task automatic check_lit(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // one clock: compare at the falling edge, then return just after the rising edge
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
  endtask

  // mode 0: random stalls and random in_en during busy
  // mode 1: back-to-back beats, in_en low during busy
  // mode 2: 5-cycle stall inside the word, in_en high during busy
  task automatic send_word(input logic [DW-1:0] w, input logic [2:0] fn, input int mode);
    for (int b = 0; b < 2; b++) begin
      int ns;
      if (mode == 0)                ns = int'($urandom_range(0, 2));
      else if (mode == 2 && b == 1) ns = 5;
      else                          ns = 0;
      repeat (ns) begin
        bus.in_en  = 1'b0;
        bus.iot_in = 8'($urandom);
        bus.fn_sel = 3'($urandom);
        tick();
      end
      bus.in_en  = 1'b1;
      bus.iot_in = (b == 0) ? w[15:8] : w[7:0];
      bus.fn_sel = (b == 0 && m_widx == 0) ? fn : 3'($urandom);
      tick();
    end
    exp_busy   = 1'b1;
    bus.in_en  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : 1'($urandom);
    bus.iot_in = 8'($urandom);
    bus.fn_sel = 3'($urandom);
    tick();
    exp_busy  = 1'b0;
    model_word(w, fn);
    bus.in_en = 1'b0;
  endtask

  task automatic send_batch(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                            input logic [2:0] fn, input int mode);
    send_word(w0, fn, mode);
    send_word(w1, fn, mode);
    send_word(w2, fn, mode);
    send_word(w3, fn, mode);
  endtask

  initial begin
    int s0;
    logic [2:0] rfn;
    n_vec = 0; n_bad = 0; n_strobe = 0; cyc = 0;
    rst = 1'b0;
    bus.in_en = 1'b0; bus.iot_in = '0; bus.fn_sel = '0;
    bus.low_bound = '0; bus.high_bound = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // fn 1 max
    s0 = n_strobe;
    send_batch(16'h0102, 16'h0304, 16'h00FF, 16'h0300, 3'd1, 1);
    tick();
    check_lit("max_count", n_strobe - s0, 1);
    check_lit("max_value", int'(bus.iot_out), 16'h0304);

    // fn 3 average with carry into the wide accumulator
    s0 = n_strobe;
    send_batch(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0003, 3'd3, 1);
    tick();
    check_lit("avg_count", n_strobe - s0, 1);
    check_lit("avg_value", int'(bus.iot_out), 16'h8000);

    // fn 4 extract, strict bounds
    bus.low_bound = 16'h1000; bus.high_bound = 16'h2000;
    s0 = n_strobe;
    send_batch(16'h1000, 16'h1001, 16'h2000, 16'h1FFF, 3'd4, 1);
    tick();
    check_lit("extract_count", n_strobe - s0, 2);
    check_lit("extract_last", int'(bus.iot_out), 16'h1FFF);

    // fn 6 peak across three batches
    s0 = n_strobe;
    send_batch(16'h0100, 16'h0500, 16'h0200, 16'h0300, 3'd6, 1);
    tick();
    check_lit("peak1_count", n_strobe - s0, 1);
    check_lit("peak1_value", int'(bus.iot_out), 16'h0500);
    s0 = n_strobe;
    send_batch(16'h0500, 16'h0000, 16'h0001, 16'h0400, 3'd6, 1);
    tick();
    check_lit("peak2_count", n_strobe - s0, 0);
    send_batch(16'h0010, 16'h0600, 16'h0020, 16'h0030, 3'd6, 1);
    tick();
    check_lit("peak3_count", n_strobe - s0, 1);
    check_lit("peak3_value", int'(bus.iot_out), 16'h0600);

    // stalls inside words and in_en during busy
    s0 = n_strobe;
    send_batch(16'h0102, 16'h0304, 16'h00FF, 16'h0300, 3'd1, 2);
    tick();
    check_lit("stall_count", n_strobe - s0, 1);
    check_lit("stall_value", int'(bus.iot_out), 16'h0304);

    // inverted window: extract never fires, exclude always fires
    bus.low_bound = 16'h8000; bus.high_bound = 16'h4000;
    s0 = n_strobe;
    send_batch(16'h5000, 16'h3000, 16'h9000, 16'h6000, 3'd4, 1);
    tick();
    check_lit("inv_extract_count", n_strobe - s0, 0);
    s0 = n_strobe;
    send_batch(16'h5000, 16'h3000, 16'h9000, 16'h6000, 3'd5, 1);
    tick();
    check_lit("inv_exclude_count", n_strobe - s0, 4);
    check_lit("inv_exclude_last", int'(bus.iot_out), 16'h6000);

    // fn 0 consumes a batch silently
    s0 = n_strobe;
    send_batch(16'h1234, 16'hFFFF, 16'h0000, 16'h7777, 3'd0, 0);
    tick();
    check_lit("fn0_count", n_strobe - s0, 0);
    check_lit("fn0_hold", int'(bus.iot_out), 16'h6000);

    // reset after three beats discards the partial word
    send_word(16'hAAAA, 3'd2, 1);
    bus.in_en = 1'b1; bus.iot_in = 8'h55; bus.fn_sel = 3'd7;
    tick();
    rst = 1'b0;
    bus.in_en = 1'b0;
    model_reset();
    #1;
    check_lit("rst_out", int'(bus.iot_out), 0);
    check_lit("rst_busy", int'(bus.busy), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    s0 = n_strobe;
    send_batch(16'h0102, 16'h0304, 16'h00FF, 16'h0300, 3'd1, 1);
    tick();
    check_lit("post_rst_count", n_strobe - s0, 1);
    check_lit("post_rst_value", int'(bus.iot_out), 16'h0304);

    // randomized batches
    rfn = 3'd6;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) rfn = 3'($urandom);
      bus.low_bound  = 16'($urandom);
      bus.high_bound = ($urandom_range(0, 3) == 0) ? bus.low_bound - 16'($urandom_range(0, 4))
                                                   : 16'($urandom);
      for (int j = 0; j < GR; j++) begin
        logic [DW-1:0] w;
        w = ($urandom_range(0, 2) == 0) ? bus.low_bound + 16'($urandom_range(0, 2)) - 16'd1
                                        : 16'($urandom);
        send_word(w, rfn, 0);
      end
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
